// File: rtl/dmem_ws.sv
// dmem_ws: wait-stated data memory with a req/ready handshake.
// It supports byte, halfword and word access, sign or zero extension on loads,
// and reports misaligned accesses or reserved sizes through err.
//
// Ports:
//   clk    - clock; all state changes happen on the rising edge
//   reset  - asynchronous, active-low reset
//   req    - access request, taken in IDLE or RESP
//   we     - 1 = store, 0 = load
//   size   - 00 byte, 01 halfword, 10 word, 11 reserved
//   sext   - loads only: sign-extend byte/halfword results
//   a      - byte address; bits above the array size alias
//   wd     - store data, right-justified
//   rd     - load result, valid while ready is high
//   ready  - one-cycle completion pulse
//   err    - valid with ready: misaligned access or reserved size
//   busy   - high while an accepted request is waiting
module dmem_ws #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] a;
    logic [31:0] wd;
  } acc_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  acc_t          q, in_acc, cur;
  logic          accept, commit, bad, wr_en;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdata, rword, shifted, ldata;
  logic [31:0]   mem [DEPTH];
  logic          unused_a;

  // Request capture; with zero wait states the commit edge is the accept edge,
  // so the access being committed is the incoming one rather than the latched one.
  assign accept = req && (state == S_IDLE || state == S_RESP);
  assign in_acc = '{we: we, size: size, sext: sext, a: a, wd: wd};
  assign cur    = accept ? in_acc : q;

  // Next-state and wait counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = S_RESP;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The edge entering RESP is where stores write and loads are registered.
  assign commit = (state_nxt == S_RESP);

  // Lane selection, byte enables, replicated write data and error detection.
  always_comb begin
    bad   = 1'b0;
    lane  = 2'b00;
    be    = 4'b0000;
    wdata = cur.wd;
    unique case (cur.size)
      SZ_B: begin
        lane  = cur.a[1:0];
        be    = 4'b0001 << cur.a[1:0];
        wdata = {4{cur.wd[7:0]}};
      end
      SZ_H: begin
        lane  = {cur.a[1], 1'b0};
        be    = cur.a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cur.wd[15:0]}};
        bad   = cur.a[0];
      end
      SZ_W: begin
        be  = 4'b1111;
        bad = (cur.a[1:0] != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

  // Upper address bits alias and are intentionally ignored.
  assign widx     = cur.a[AW+1:2];
  assign unused_a = ^cur.a[31:AW+2];

  // Load extraction: right-justify the lane(s), then extend.
  assign rword   = mem[widx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    ldata = rword;
    unique case (cur.size)
      SZ_B:    ldata = {{24{cur.sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    ldata = {{16{cur.sext & shifted[15]}}, shifted[15:0]};
      default: ldata = rword;
    endcase
  end

  // Reset blocks writes so a request seen during reset cannot commit.
  assign wr_en = commit && cur.we && !bad && reset;

  // Memory array: no reset, contents persist across reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // State, counter, captured request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      q     <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rd    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == S_WAIT);
      ready <= commit;
      err   <= commit && bad;
      if (accept) begin
        q <= in_acc;
      end
      if (commit) begin
        rd <= (cur.we || bad) ? '0 : ldata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: self-checking bench for dmem_ws. It runs three instances with
// WAIT_STATES of 0, 1 and 3. Each instance is checked every cycle against a
// byte-array memory model and a countdown-to-response timing model.
module tb_dmem_ws;

  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int ws, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s (WAIT_STATES=%0d) t=%0t: got %h, expected %h", nm, ws, $time, act, want);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    logic        rst_n, req, we, sext, ready, err, busy;
    logic [1:0]  size;
    logic [31:0] a, wd, rd;
    logic        fin = 1'b0;

    // Model: byte-addressed memory, plus cycles remaining until ready (1 = ready now).
    logic [7:0]  mm [4*DEPTH];
    int          left;
    logic        p_we, p_sext;
    logic [1:0]  p_size;
    logic [31:0] p_a, p_wd;
    logic [31:0] last_rd;
    logic        last_err;

    dmem_ws #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(rst_n), .req(req), .we(we), .size(size), .sext(sext),
      .a(a), .wd(wd), .rd(rd), .ready(ready), .err(err), .busy(busy)
    );

    // Apply the pending access to the model and produce the expected response.
    task automatic resolve(output logic [31:0] erd, output logic eerr);
      int bi, nb;
      logic [31:0] w;
      bi   = int'(p_a % (4 * DEPTH));
      nb   = 1 << p_size;
      eerr = (p_size == 2'd3) || (p_size == 2'd1 && p_a[0]) || (p_size == 2'd2 && p_a[1:0] != 2'd0);
      erd  = '0;
      if (!eerr) begin
        if (p_we) begin
          for (int i = 0; i < nb; i++) mm[bi + i] = p_wd[8*i +: 8];
        end else begin
          w = '0;
          for (int i = 0; i < nb; i++) w[8*i +: 8] = mm[bi + i];
          if (p_sext && nb < 4 && w[8*nb-1]) w = w | (32'hFFFF_FFFF << (8*nb));
          erd = w;
        end
      end
    endtask

    task automatic check_cycle();
      logic [31:0] erd;
      logic        eerr;
      chk("ready", WS, 32'(ready), 32'(left == 1));
      chk("busy", WS, 32'(busy), 32'(left > 1));
      if (left == 1) begin
        resolve(erd, eerr);
        chk("err", WS, 32'(err), 32'(eerr));
        if (!p_we || eerr) chk("rd", WS, rd, erd);
        last_rd  = rd;
        last_err = err;
      end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic x,
                         input logic [31:0] ad, input logic [31:0] d, output logic acc);
      req = r; we = w; size = s; sext = x; a = ad; wd = d;
      acc = r && (left <= 1);
      if (acc) begin
        p_we = w; p_size = s; p_sext = x; p_a = ad; p_wd = d;
        left = int'(WS) + 1;
      end else if (left > 0) begin
        left--;
      end
    endtask

    task automatic step(input logic r, input logic w, input logic [1:0] s, input logic x,
                        input logic [31:0] ad, input logic [31:0] d, output logic acc);
      @(negedge clk);
      check_cycle();
      drive(r, w, s, x, ad, d, acc);
    endtask

    task automatic drain();
      logic acc;
      for (int k = 0; k < int'(WS) + 3 && left != 0; k++) step(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, acc);
    endtask

    task automatic op(input logic w, input logic [1:0] s, input logic x, input logic [31:0] ad, input logic [31:0] d);
      logic acc;
      step(1'b1, w, s, x, ad, d, acc);
      drain();
    endtask

    task automatic mid_reset();
      @(negedge clk);
      check_cycle();
      rst_n = 1'b0;
      req   = 1'b0;
      left  = 0;
      #1;
      chk("rst_ready", WS, 32'(ready), 32'd0);
      chk("rst_err", WS, 32'(err), 32'd0);
      chk("rst_busy", WS, 32'(busy), 32'd0);
      chk("rst_rd", WS, rd, 32'd0);
      @(negedge clk);
      check_cycle();
      rst_n = 1'b1;
    endtask

    initial begin
      logic        acc;
      logic [31:0] r32;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; a = '0; wd = '0;
      left = 0; last_rd = '0; last_err = 1'b0;
      #1;
      chk("reset_ready", WS, 32'(ready), 32'd0);
      chk("reset_err", WS, 32'(err), 32'd0);
      chk("reset_busy", WS, 32'(busy), 32'd0);
      chk("reset_rd", WS, rd, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill the whole array so every later load has known contents.
      for (int i = 0; i < int'(DEPTH); i++) begin
        r32 = $urandom;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) step(1'b1, 1'b1, 2'd2, 1'b0, 32'(i * 4), r32, acc);
      end
      drain();

      // Word store then load.
      op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
      op(1'b0, 2'd2, 1'b0, 32'h10, '0);
      chk("lit_word", WS, last_rd, 32'hDEAD_BEEF);
      chk("lit_word_err", WS, 32'(last_err), 32'd0);

      // Byte/halfword stores and extension.
      op(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
      op(1'b1, 2'd0, 1'b0, 32'h21, 32'h80);
      op(1'b0, 2'd0, 1'b1, 32'h21, '0);
      chk("lit_byte_sext", WS, last_rd, 32'hFFFF_FF80);
      op(1'b0, 2'd0, 1'b0, 32'h21, '0);
      chk("lit_byte_zext", WS, last_rd, 32'h0000_0080);
      op(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234);
      op(1'b0, 2'd2, 1'b0, 32'h20, '0);
      chk("lit_half_word", WS, last_rd, 32'h1234_8000);

      // Misaligned store is flagged and leaves memory unchanged.
      op(1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A5_A5A5);
      op(1'b1, 2'd2, 1'b0, 32'h31, 32'hFFFF_FFFF);
      chk("lit_mis_err", WS, 32'(last_err), 32'd1);
      chk("lit_mis_rd", WS, last_rd, 32'd0);
      op(1'b0, 2'd2, 1'b0, 32'h30, '0);
      chk("lit_mis_keep", WS, last_rd, 32'hA5A5_A5A5);

      // Back-to-back loads with req held high.
      for (int i = 0; i < 4; i++) begin
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) step(1'b1, 1'b0, 2'd2, 1'b0, 32'(i * 4), '0, acc);
      end
      drain();

      // Address aliasing modulo the array size.
      op(1'b1, 2'd2, 1'b0, 32'h100, 32'h0BAD_F00D);
      op(1'b0, 2'd2, 1'b0, 32'h000, '0);
      chk("lit_alias", WS, last_rd, 32'h0BAD_F00D);

      // Reset during an in-flight store; it only survives if it already committed.
      op(1'b1, 2'd2, 1'b0, 32'h04, 32'h1122_3344);
      step(1'b1, 1'b1, 2'd0, 1'b0, 32'h04, 32'h55, acc);
      mid_reset();
      op(1'b0, 2'd0, 1'b0, 32'h04, '0);
      chk("lit_reset_store", WS, last_rd, (WS == 0) ? 32'h55 : 32'h44);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
        r32 = $urandom;
        if ($urandom_range(0, 1) == 1) r32[1:0] = 2'b00;
        step($urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom), 1'($urandom), r32, $urandom, acc);
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 50000; c++) begin
      @(posedge clk);
      if (gi[0].fin && gi[1].fin && gi[2].fin) break;
    end
    if (!(gi[0].fin && gi[1].fin && gi[2].fin)) begin
      checks++;
      $display("FAIL timeout: got unfinished instances, expected all done");
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
